// File: rtl/btn_debounce.sv
// Four-button debouncer with synchronisers, press pulses and an event strobe carrying a code and the switch value.
// Optional auto-repeat while a button is held: define BTN_AUTOREPEAT_EN.
module btn_debounce #(
    parameter int BOUND         = 1000000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN_SOUTH,
    input  logic       BTN_WEST,
    input  logic       BTN_NORTH,
    input  logic       BTN_EAST,
    input  logic [3:0] SW,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic [3:0] evt_sw
);

    localparam int CW = $clog2(BOUND);

    if (BOUND < 2 || BOUND > 2097151 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce: parameter out of range");
    end

    logic [3:0]    btn_raw;
    logic [3:0]    btn_s1_q, btn_s2_q;
    logic [3:0]    sw_s1_q, sw_s2_q;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    level_q, level_d, level_prev_q;
    logic [3:0]    press_q, press_d;
    logic [1:0]    evt_code_q, evt_code_d;
    logic [3:0]    evt_sw_q, evt_sw_d;

    assign btn_raw = {BTN_SOUTH, BTN_WEST, BTN_NORTH, BTN_EAST};

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_q [4];
    logic [RW-1:0] rpt_d [4];
    logic [3:0]    rpt_hit;

    // Timer loads on the initial pulse, then reloads with the period each time it expires.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rpt_hit[i] = level_q[i] & level_prev_q[i] & (rpt_q[i] == '0);
            if (!level_q[i]) begin
                rpt_d[i] = '0;
            end else if (!level_prev_q[i]) begin
                rpt_d[i] = RW'(REPEAT_DELAY - 1);
            end else if (rpt_q[i] == '0) begin
                rpt_d[i] = RW'(REPEAT_PERIOD - 1);
            end else begin
                rpt_d[i] = rpt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rpt_q[i] <= '0;
            end else begin
                rpt_q[i] <= rpt_d[i];
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            level_d[i] = level_q[i];
            cnt_d[i]   = '0;
            if (btn_s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CW'(BOUND - 1)) begin
                    level_d[i] = btn_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        press_d = (level_q & ~level_prev_q) | rpt_hit;
`else
        press_d = level_q & ~level_prev_q;
`endif

        evt_code_d = evt_code_q;
        evt_sw_d   = evt_sw_q;
        if (|press_d) begin
            evt_sw_d = sw_s2_q;
            // SOUTH sits in the MSB and wins ties.
            if (press_d[3]) begin
                evt_code_d = 2'd0;
            end else if (press_d[2]) begin
                evt_code_d = 2'd1;
            end else if (press_d[1]) begin
                evt_code_d = 2'd2;
            end else begin
                evt_code_d = 2'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            evt_code_q   <= '0;
            evt_sw_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_s1_q     <= btn_raw;
            btn_s2_q     <= btn_s1_q;
            sw_s1_q      <= SW;
            sw_s2_q      <= sw_s1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            evt_code_q   <= evt_code_d;
            evt_sw_q     <= evt_sw_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign evt_valid = |press_q;
    assign evt_code  = evt_code_q;
    assign evt_sw    = evt_sw_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: table-driven vectors, hand-written reset/repeat sequences,
// and random stimulus checked against a sliding-window reference model.
module tb_btn_debounce;

    localparam int BOUND = 4;
    localparam int RDLY  = 20;
    localparam int RPER  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [3:0] sw  = 4'b0000;
    logic [3:0] btn_level, btn_press, evt_sw;
    logic       evt_valid;
    logic [1:0] evt_code;

    int n_chk  = 0;
    int n_fail = 0;

    btn_debounce #(.BOUND(BOUND), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)) dut (
        .clk       (clk),
        .rst       (rst),
        .BTN_SOUTH (btn[3]),
        .BTN_WEST  (btn[2]),
        .BTN_NORTH (btn[1]),
        .BTN_EAST  (btn[0]),
        .SW        (sw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_sw    (evt_sw)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips once the last BOUND synchronised samples all disagree with it.
    bit [3:0]       m_a, m_b, m_swa, m_swb;
    bit [BOUND-1:0] m_win [4];
    bit [3:0]       m_level, m_prev, m_press, m_sw;
    bit [1:0]       m_code;
    int             m_hold [4];

    always @(posedge clk) begin
        bit [3:0] samp, swsamp, newp, nl;
        if (rst) begin
            m_a = 0; m_b = 0; m_swa = 0; m_swb = 0;
            m_level = 0; m_prev = 0; m_press = 0; m_sw = 0; m_code = 0;
            for (int i = 0; i < 4; i++) begin
                m_win[i]  = '0;
                m_hold[i] = 0;
            end
        end else begin
            samp = m_b; swsamp = m_swb;
            m_b = m_a; m_a = btn;
            m_swb = m_swa; m_swa = sw;
            newp = m_level & ~m_prev;
            for (int i = 0; i < 4; i++) begin
                if (m_level[i] && m_prev[i]) begin
                    m_hold[i]++;
`ifdef BTN_AUTOREPEAT_EN
                    if (m_hold[i] == RDLY || (m_hold[i] > RDLY && (m_hold[i] - RDLY) % RPER == 0))
                        newp[i] = 1'b1;
`endif
                end else begin
                    m_hold[i] = 0;
                end
                m_win[i] = {m_win[i][BOUND-2:0], samp[i]};
                nl[i] = (m_win[i] == {BOUND{~m_level[i]}}) ? ~m_level[i] : m_level[i];
            end
            m_prev = m_level; m_level = nl; m_press = newp;
            if (|newp) begin
                m_sw = swsamp;
                if (newp[3]) m_code = 2'd0;
                else if (newp[2]) m_code = 2'd1;
                else if (newp[1]) m_code = 2'd2;
                else m_code = 2'd3;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input bit [3:0] l, input bit [3:0] p,
                           input bit v, input bit [1:0] c, input bit [3:0] s);
        chk({tag, ".level"}, btn_level, l);
        chk({tag, ".press"}, btn_press, p);
        chk({tag, ".valid"}, evt_valid, v);
        chk({tag, ".code"},  evt_code,  c);
        chk({tag, ".sw"},    evt_sw,    s);
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] btn;
        bit [3:0] sw;
        int       n;
        bit [3:0] lvl;
        bit [3:0] prs;
        bit       vld;
        bit [1:0] code;
        bit [3:0] esw;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int found, pulses;
        bit exp_p;

        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0010, 4'b0000, 5, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0010, 1'b1, 2'd2, 4'b0000};
        tbl[4]  = '{1'b0, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 1'b0, 2'd2, 4'b0000};
        tbl[5]  = '{1'b0, 4'b0000, 4'b1010, 5, 4'b0010, 4'b0000, 1'b0, 2'd2, 4'b0000};
        tbl[6]  = '{1'b0, 4'b0000, 4'b1010, 1, 4'b0000, 4'b0000, 1'b0, 2'd2, 4'b0000};
        tbl[7]  = '{1'b0, 4'b0000, 4'b1010, 2, 4'b0000, 4'b0000, 1'b0, 2'd2, 4'b0000};
        tbl[8]  = '{1'b0, 4'b1001, 4'b1010, 5, 4'b0000, 4'b0000, 1'b0, 2'd2, 4'b0000};
        tbl[9]  = '{1'b0, 4'b1001, 4'b1010, 1, 4'b1001, 4'b0000, 1'b0, 2'd2, 4'b0000};
        tbl[10] = '{1'b0, 4'b1001, 4'b1010, 1, 4'b1001, 4'b1001, 1'b1, 2'd0, 4'b1010};
        tbl[11] = '{1'b0, 4'b1001, 4'b0101, 6, 4'b1001, 4'b0000, 1'b0, 2'd0, 4'b1010};
        tbl[12] = '{1'b0, 4'b1101, 4'b0101, 3, 4'b1001, 4'b0000, 1'b0, 2'd0, 4'b1010};
        tbl[13] = '{1'b0, 4'b1001, 4'b0101, 1, 4'b1001, 4'b0000, 1'b0, 2'd0, 4'b1010};
        tbl[14] = '{1'b0, 4'b1101, 4'b0101, 3, 4'b1001, 4'b0000, 1'b0, 2'd0, 4'b1010};
        tbl[15] = '{1'b0, 4'b1001, 4'b0101, 6, 4'b1001, 4'b0000, 1'b0, 2'd0, 4'b1010};

        for (int v = 0; v < 16; v++) begin
            rst = tbl[v].rst; btn = tbl[v].btn; sw = tbl[v].sw;
            step(tbl[v].n);
            chk_all($sformatf("vec%0d", v), tbl[v].lvl, tbl[v].prs, tbl[v].vld, tbl[v].code, tbl[v].esw);
        end

        // Reset pulse mid-debounce, then a fresh press from the held button.
        rst = 1'b1; btn = 4'b0000; sw = 4'b0000; step(1);
        rst = 1'b0; step(2);
        btn = 4'b0001; step(4);
        rst = 1'b1; step(1);
        chk_all("rst_mid", 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000);
        rst = 1'b0; step(5);
        chk("rel_r5.level", btn_level, 0);
        step(1);
        chk("rel_r6.level", btn_level, 1);
        chk("rel_r6.press", btn_press, 0);
        step(1);
        chk_all("rel_r7", 4'b0001, 4'b0001, 1'b1, 2'd3, 4'b0000);
        step(1);
        chk("rel_r8.press", btn_press, 0);

        // Reset landing on the edge that would complete the debounce.
        rst = 1'b1; step(1);
        rst = 1'b0; step(5);
        rst = 1'b1; step(1);
        chk("rst_override.level", btn_level, 0);
        chk("rst_override.press", btn_press, 0);

        // Held NORTH: initial pulse, then repeats only when auto-repeat is built in.
        rst = 1'b0; btn = 4'b0010;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1);
            if (btn_press[1]) found = 1;
        end
        chk("rpt_first_found", found, 1);
        pulses = 0;
        for (int j = 1; j <= 40; j++) begin
            step(1);
`ifdef BTN_AUTOREPEAT_EN
            exp_p = (j == 20 || j == 26 || j == 32 || j == 38);
`else
            exp_p = 1'b0;
`endif
            if (btn_press[1]) pulses++;
            chk($sformatf("rpt_j%0d", j), btn_press[1], exp_p);
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("rpt_count", pulses, 4);
`else
        chk("rpt_count", pulses, 0);
`endif

        // Random stimulus against the reference model.
        rst = 1'b1; btn = 4'b0000; step(1);
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) btn[b] = ~btn[b];
            end
            if ($urandom_range(9) == 0) sw = 4'($urandom);
            rst = ($urandom_range(199) == 0);
            step(1);
            chk("rnd.level", btn_level, m_level);
            chk("rnd.press", btn_press, m_press);
            chk("rnd.valid", evt_valid, |m_press);
            chk("rnd.code",  evt_code,  m_code);
            chk("rnd.sw",    evt_sw,    m_sw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter BOUND, default 1000000: consecutive stable cycles required to accept a button level change (legal range 2..2^21-1).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: held cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 BTN_SOUTH, BTN_WEST, BTN_NORTH, BTN_EAST  in  1 each  raw asynchronous pushbuttons, active-high.
REQ-007 SW  in  4  raw asynchronous slide switches.
REQ-008 btn_level  out  4  debounced button levels, bit order {SOUTH,WEST,NORTH,EAST}.
REQ-009 btn_press  out  4  one-cycle press pulses, same bit order.
REQ-010 evt_valid  out  1  one-cycle strobe: at least one press pulse this cycle.
REQ-011 evt_code  out  2  pressed-button code: SOUTH=0, WEST=1, NORTH=2, EAST=3.
REQ-012 evt_sw  out  4  synchronised SW value captured with the event.

Function
REQ-013 Each button and each SW bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-014 Each button SHALL own a counter: clear when synchronised value equals btn_level; increment otherwise.
REQ-015 When the counter equals BOUND-1 and the value still differs, btn_level SHALL take the synchronised value and the counter SHALL clear.
REQ-016 A raw level change held shorter than BOUND cycles SHALL leave btn_level unchanged; any bounce SHALL restart the count from 0.
REQ-017 Releases SHALL be debounced identically to presses.
REQ-018 btn_press[i] SHALL be a registered pulse, high for exactly one cycle on each 0->1 transition of btn_level[i].
REQ-019 Latency: raw input rising before edge k and held stable SHALL set btn_level after edge k+BOUND+1 and btn_press after edge k+BOUND+2.
REQ-020 evt_valid SHALL equal OR of btn_press, in the same cycle.
REQ-021 On simultaneous presses evt_code SHALL encode the highest-priority pulse, SOUTH>WEST>NORTH>EAST; lower-priority btn_press bits SHALL still pulse.
REQ-022 evt_code and evt_sw SHALL be updated only in a cycle where evt_valid is high and SHALL hold their values otherwise.
REQ-023 evt_sw SHALL equal the synchronised SW value sampled at the edge that raises evt_valid.
REQ-024 Each button SHALL be processed independently; activity on one SHALL not alter another's counter.

Reset
REQ-025 On rst high at a clock edge: synchronisers, counters, btn_level, btn_press, evt_valid, evt_code, evt_sw SHALL all become 0.
REQ-026 rst SHALL override all other activity, including a debounce completing on the same edge.
REQ-027 A button held through reset release SHALL be treated as a new press, producing a pulse BOUND+3 edges after the first non-reset edge.

Configuration
REQ-028 Macro BTN_AUTOREPEAT_EN defined: while btn_level[i] stays 1, btn_press[i] SHALL pulse again after REPEAT_DELAY cycles from the initial pulse, then every REPEAT_PERIOD cycles; repeat timer clears on release or rst; repeats SHALL drive evt_valid/evt_code/evt_sw as normal presses.
REQ-029 Macro BTN_AUTOREPEAT_EN undefined: exactly one btn_press pulse per debounced press; no repeat logic synthesised; REPEAT_DELAY and REPEAT_PERIOD ignored.

Verification (BOUND=4, REPEAT_DELAY=20, REPEAT_PERIOD=6)
REQ-030 BTN_NORTH raised before edge 10, held -> btn_level[1]=1 after edge 15; btn_press=4'b0010, evt_valid=1, evt_code=2 for the one cycle after edge 16 only.
REQ-031 BTN_WEST high for 3 cycles, low 1 cycle, high for 3 cycles -> no btn_press, btn_level stays 0.
REQ-032 BTN_SOUTH and BTN_EAST raised on the same cycle, SW=4'b1010 -> btn_press=4'b1001, evt_code=0, evt_sw=4'b1010; SW later set to 4'b0101 with no press -> evt_sw stays 4'b1010.
REQ-033 BTN_EAST held, rst pulsed one cycle mid-debounce (counter=2) -> all outputs 0 after rst; press pulse at edge rst_release+7.
REQ-034 Press then release held 4 cycles -> btn_level returns 0 with no btn_press pulse on release.
REQ-035 BTN_AUTOREPEAT_EN, BTN_NORTH held 40 cycles after first pulse -> extra pulses 20, 26, 32, 38 cycles after it; without macro -> single pulse only.
